// File: rtl/counter_if.sv
// counter_if: control/status bundle between a counter and the logic that drives it.
//   enable  - count-enable, active-high
//   clear   - synchronous clear-to-zero, active-high
//   wrap    - 1: roll over to 0 at max, 0: saturate at max
//   max     - unsigned terminal count, sampled every cycle
//   count   - registered current count
//   at_max  - combinational count >= max
// Modports: master drives the controls, slave is the counter itself.
interface counter_if #(
    parameter int unsigned N = 4
);
    logic         enable;
    logic         clear;
    logic         wrap;
    logic [N-1:0] max;
    logic [N-1:0] count;
    logic         at_max;

    modport master (
        output enable,
        output clear,
        output wrap,
        output max,
        input  count,
        input  at_max
    );

    modport slave (
        input  enable,
        input  clear,
        input  wrap,
        input  max,
        output count,
        output at_max
    );
endinterface

// File: rtl/counter.sv
// counter: N-bit up-counter with terminal count, rollover/saturate select and sync clear.
//   clk  - single clock, state updates on rising edge
//   nrst - asynchronous reset, active-high despite the name (1 resets, 0 runs)
//   bus  - counter_if.slave: enable, clear, wrap, max in; count, at_max out
// Next-count priority: clear, then enable, then hold. All inputs are assumed
// synchronous to clk; no synchronizers are included.
module counter #(
    parameter int unsigned N = 4
) (
    input logic      clk,
    input logic      nrst,
    counter_if.slave bus
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;
    logic         at_max;

    // Uses >= rather than == so a count left above a lowered max still counts as terminal.
    assign at_max = (count_q >= bus.max);

    always_comb begin
        count_d = count_q;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.enable) begin
            if (!at_max) begin
                count_d = count_q + 1'b1;
            end else if (bus.wrap) begin
                count_d = '0;
            end else begin
                // Saturate; also pulls an over-range count down to a lowered max.
                count_d = bus.max;
            end
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.at_max = at_max;

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed self-checking bench for counter at N=4, N=2 and N=8.
module tb_counter;

    logic clk;
    logic nrst;

    int checks = 0;
    int errors = 0;

    counter_if #(.N(4)) bus4 ();
    counter_if #(.N(2)) bus2 ();
    counter_if #(.N(8)) bus8 ();

    counter #(.N(4)) u_dut4 (.clk(clk), .nrst(nrst), .bus(bus4.slave));
    counter #(.N(2)) u_dut2 (.clk(clk), .nrst(nrst), .bus(bus2.slave));
    counter #(.N(8)) u_dut8 (.clk(clk), .nrst(nrst), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear4();
        bus4.clear = 1'b1;
        step();
        bus4.clear = 1'b0;
    endtask

    // Expected sequences for the N=4 runs.
    logic [3:0] exp_roll [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2};
    logic [3:0] exp_sat  [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5};
    logic [1:0] exp_n2   [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        nrst = 1'b1;
        bus4.enable = 1'b0; bus4.clear = 1'b0; bus4.wrap = 1'b1; bus4.max = 4'd5;
        bus2.enable = 1'b0; bus2.clear = 1'b0; bus2.wrap = 1'b1; bus2.max = 2'd3;
        bus8.enable = 1'b0; bus8.clear = 1'b0; bus8.wrap = 1'b1; bus8.max = 8'd255;

        // Power-on reset
        step();
        check("por_count", bus4.count, 0);
        check("por_at_max", bus4.at_max, 0);
        nrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_hold", bus4.count, 0);
        end

        // Rollover at max=5
        bus4.wrap = 1'b1;
        bus4.enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("roll_count", bus4.count, exp_roll[i]);
            check("roll_at_max", bus4.at_max, exp_roll[i] == 4'd5);
        end
        bus4.enable = 1'b0;

        // Saturation at max=5
        clear4();
        check("sat_clear", bus4.count, 0);
        bus4.wrap = 1'b0;
        bus4.enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("sat_count", bus4.count, exp_sat[i]);
            check("sat_at_max", bus4.at_max, exp_sat[i] == 4'd5);
        end
        bus4.enable = 1'b0;

        // Clear beats enable
        clear4();
        bus4.enable = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("pre_clr", bus4.count, 3);
        bus4.clear = 1'b1;
        step();
        check("clr_prio", bus4.count, 0);
        bus4.clear = 1'b0;
        step();
        check("clr_resume", bus4.count, 1);
        bus4.enable = 1'b0;

        // Lowered max, wrap=1
        bus4.max = 4'd15;
        bus4.wrap = 1'b1;
        clear4();
        bus4.enable = 1'b1;
        for (int i = 0; i < 9; i++) step();
        bus4.enable = 1'b0;
        check("low_pre9", bus4.count, 9);
        check("low_pre_flag", bus4.at_max, 0);
        bus4.max = 4'd4;
        #1;
        check("low_flag_imm", bus4.at_max, 1);
        bus4.enable = 1'b1;
        step();
        check("low_wrap", bus4.count, 0);
        bus4.enable = 1'b0;

        // Lowered max, wrap=0 clamps down to max
        bus4.max = 4'd15;
        clear4();
        bus4.enable = 1'b1;
        for (int i = 0; i < 9; i++) step();
        bus4.enable = 1'b0;
        bus4.max = 4'd4;
        bus4.wrap = 1'b0;
        #1;
        check("low_flag_imm2", bus4.at_max, 1);
        bus4.enable = 1'b1;
        step();
        check("low_clamp", bus4.count, 4);
        bus4.enable = 1'b0;

        // max=0 pins count at 0
        clear4();
        bus4.max = 4'd0;
        bus4.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("max0_count", bus4.count, 0);
            check("max0_flag", bus4.at_max, 1);
        end
        bus4.enable = 1'b0;

        // Async reset between edges at count=7
        bus4.max = 4'd15;
        bus4.wrap = 1'b1;
        clear4();
        bus4.enable = 1'b1;
        for (int i = 0; i < 7; i++) step();
        bus4.enable = 1'b0;
        check("ar_pre7", bus4.count, 7);
        #2;
        nrst = 1'b1;
        #1;
        check("ar_count", bus4.count, 0);
        check("ar_flag", bus4.at_max, 0);
        bus4.max = 4'd0;
        #1;
        check("ar_flag_max0", bus4.at_max, 1);
        bus4.max = 4'd15;
        // Enable and clear ignored while in reset
        bus4.enable = 1'b1;
        step();
        check("ar_ignore_en", bus4.count, 0);
        nrst = 1'b0;
        step();
        check("ar_resume", bus4.count, 1);
        bus4.enable = 1'b0;

        // N=2: max=3 full-range rollover
        bus2.clear = 1'b1;
        step();
        bus2.clear = 1'b0;
        bus2.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("n2_count", bus2.count, exp_n2[i]);
        end
        step();
        bus2.enable = 1'b0;
        check("n2_pre_ar", bus2.count, 1);

        // N=8: max=255 rollover
        bus8.clear = 1'b1;
        step();
        bus8.clear = 1'b0;
        bus8.enable = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            step();
            check("n8_count", bus8.count, i);
        end
        check("n8_at_max", bus8.at_max, 1);
        step();
        check("n8_roll", bus8.count, 0);
        check("n8_roll_flag", bus8.at_max, 0);
        step();
        bus8.enable = 1'b0;
        check("n8_pre_ar", bus8.count, 1);

        // Async reset between edges for N=2 and N=8
        #2;
        nrst = 1'b1;
        #1;
        check("n2_ar", bus2.count, 0);
        check("n8_ar", bus8.count, 0);
        step();
        nrst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001: Parameter N SHALL have default 4 and set the width in bits of max and count, with legal range 1..32.
REQ-002: Port clk, input, 1 bit, SHALL be the single clock, and all state SHALL update on its rising edge.
REQ-003: Port nrst, input, 1 bit, SHALL be the reset, asynchronous and active-high: nrst=1 resets, nrst=0 runs.
REQ-004: Port enable, input, 1 bit, SHALL be the count-enable, active-high.
REQ-005: Port clear, input, 1 bit, SHALL be the synchronous clear-to-zero, active-high.
REQ-006: Port wrap, input, 1 bit, SHALL select rollover: 1 means roll over to 0 at max, 0 means saturate at max.
REQ-007: Port max, input, N bits, SHALL be the unsigned terminal count value, sampled every cycle.
REQ-008: Port count, output, N bits, SHALL be the registered current count value.
REQ-009: Port at_max, output, 1 bit, SHALL be the combinational flag defined as count >= max.

Function
REQ-010: Next-count priority per rising edge SHALL be, highest first: clear, then enable, then hold.
REQ-011: clear=1 SHALL load count=0 on the next edge, regardless of enable, wrap or max.
REQ-012: clear=0, enable=1 and count < max SHALL load count+1.
REQ-013: clear=0, enable=1, count >= max and wrap=1 SHALL load count=0.
REQ-014: clear=0, enable=1, count >= max and wrap=0 SHALL load count=max, which is saturation and also clamps a count that exceeds a lowered max.
REQ-015: clear=0 and enable=0 SHALL hold count unchanged.
REQ-016: Increment SHALL be unsigned modulo 2^N, and count SHALL never exceed 2^N-1.
REQ-017: at_max SHALL track count and max combinationally with no register stage, so it reflects a changed max in the same cycle.
REQ-018: max=0 SHALL hold count at 0 while enabled, with at_max=1 permanently.
REQ-019: max=2^N-1 with wrap=1 SHALL give a full-range free-running counter of period 2^N.
REQ-020: Counting latency SHALL be one cycle: an enable sampled at edge k SHALL be visible on count after edge k.
REQ-021: Inputs SHALL be treated as synchronous to clk, and no internal input synchronizers SHALL be included.

Reset
REQ-022: nrst=1 SHALL force count=0 immediately, without waiting for a clk edge.
REQ-023: During reset, at_max SHALL equal (max==0).
REQ-024: While nrst=1, enable and clear SHALL be ignored.
REQ-025: Counting SHALL resume on the first rising edge after nrst deasserts, starting from 0.
REQ-026: Reset asserted mid-count SHALL discard the count, and no value SHALL be retained across reset.

Verification (N=4 unless stated)
REQ-027: Power-on: nrst=1 for 1 cycle with max=5 SHALL give count=0 and at_max=0, then with nrst=0 and enable=0 for 3 cycles count SHALL stay 0.
REQ-028: Rollover: max=5, wrap=1, enable=1 for 8 cycles SHALL give count 1,2,3,4,5,0,1,2, with at_max=1 only while count=5.
REQ-029: Saturate: max=5, wrap=0, enable=1 for 8 cycles SHALL give count 1..5 then hold at 5, with at_max=1 from count=5 onward.
REQ-030: Clear priority: at count=3 with clear=1 and enable=1 for 1 cycle, count SHALL become 0, then with clear=0 count SHALL become 1 on the next edge.
REQ-031: Lowered max: at count=9, changing max to 4 SHALL make at_max=1 immediately, then enable=1 SHALL give count=0 if wrap=1, or count=4 if wrap=0.
REQ-032: Async reset and widths: nrst asserted between edges at count=7 SHALL clear count to 0 before the next edge, and this SHALL be repeated for N=2 (max=3, sequence 1,2,3,0) and for N=8 (max=255, rollover 255 to 0).
